// File: rtl/dmem_stall_responder.sv
// Fixed-latency word-addressed data memory for a stalling pipeline memory stage.
// One access in flight: Stall for LATENCY cycles, then a single Done cycle with read data.
module dmem_stall_responder #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int unsigned CntW  = $clog2(LATENCY + 1);
    localparam int unsigned Words = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [15:0]            data_q, data_d;
    logic                   wr_q, wr_d;
    logic                   mem_we;
    logic [15:0]            mem_q [Words];

    logic req, legal;

    assign req      = Rd ^ Wr;
    assign legal    = req & ~Addr[0];
    assign CacheHit = 1'b0;

    // Dump requests and upper address bits are intentionally not used by the hardware.
    logic unused_inputs;
    assign unused_inputs = ^{createdump, Addr[15:ADDR_BITS+1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = wr_q;
        Stall   = 1'b0;
        Done    = 1'b0;
        err     = 1'b0;
        DataOut = 16'h0000;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rst) begin
                    if (legal) begin
                        Stall  = 1'b1;
                        idx_d  = Addr[ADDR_BITS:1];
                        data_d = DataIn;
                        wr_d   = Wr;
                        if (LATENCY == 1) begin
                            state_d = StDone;
                        end else begin
                            state_d = StBusy;
                            cnt_d   = CntW'(LATENCY - 1);
                        end
                    end else if (Rd | Wr) begin
                        err = 1'b1;
                    end
                end
            end
            StBusy: begin
                Stall = 1'b1;
                if (cnt_q > CntW'(1)) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                Done    = 1'b1;
                DataOut = wr_q ? 16'h0000 : mem_q[idx_q];
                mem_we  = wr_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            for (int unsigned i = 0; i < Words; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            if (mem_we) begin
                mem_q[idx_q] <= data_q;
            end
        end
    end

endmodule
